// File: rtl/can_irq_controller_if.sv
// Purpose : bundles the CAN interrupt controller's event, register-access and irq signals.
// Latency : n/a (wires only).
// Backpressure : none; single-cycle strobes (en_wr, clr_wr, irq_ack) with no ready path.
// Ports   : master = CAN core + register MUX/DEMUX side, slave = can_irq_controller.
interface can_irq_controller_if #(
  parameter int NUM_EVT = 12
);
  logic [NUM_EVT-1:0] evt_in;
  logic [31:0]        DEMUX2interrupt_en;
  logic               en_wr;
  logic [31:0]        DEMUX2interrupt_clr;
  logic               clr_wr;
  logic               irq_ack;
  logic [31:0]        interruptstat2MUX;
  logic [31:0]        interrupten2MUX;
  logic               irq;
  logic [3:0]         irq_vec;

  modport master (
    output evt_in, DEMUX2interrupt_en, en_wr, DEMUX2interrupt_clr, clr_wr, irq_ack,
    input  interruptstat2MUX, interrupten2MUX, irq, irq_vec
  );

  modport slave (
    input  evt_in, DEMUX2interrupt_en, en_wr, DEMUX2interrupt_clr, clr_wr, irq_ack,
    output interruptstat2MUX, interrupten2MUX, irq, irq_vec
  );
endinterface

// File: rtl/can_irq_controller.sv
// Purpose : edge-captures CAN events into W1C sticky status, masks with enable, drives irq + priority vector.
// Latency : event rise -> status same edge; -> irq/irq_vec one edge later; irq low >= HOLDOFF_CYC cycles after drop.
// Backpressure : none; strobes act on the edge they are sampled, irq_ack only honoured while irq=1.
// Ports   : sys_clk, sys_rst (sync, active-high), bus (slave modport of can_irq_controller_if).
module can_irq_controller #(
  parameter int NUM_EVT     = 12,
  parameter int HOLDOFF_CYC = 8,
  parameter int CNT_W       = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  can_irq_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  // Counter starts at HOLDOFF_CYC-1 so HOLDOFF lasts exactly HOLDOFF_CYC cycles.
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF_CYC > 0) ? CNT_W'(HOLDOFF_CYC - 1) : '0;

  logic [NUM_EVT-1:0] status, enable, evt_prev;
  logic [NUM_EVT-1:0] rise, pending, ack_mask, clr_mask;
  logic [3:0]         vec_nxt, irq_vec_q;
  logic               irq_q;
  state_t             state;
  logic [CNT_W-1:0]   cnt;

  assign rise     = bus.evt_in & ~evt_prev;
  assign pending  = status & enable;
  assign clr_mask = bus.clr_wr ? bus.DEMUX2interrupt_clr[NUM_EVT-1:0] : '0;

  // Only the vector software is currently looking at can be acknowledged.
  always_comb begin
    ack_mask = '0;
    if (bus.irq_ack && irq_q) ack_mask[irq_vec_q] = 1'b1;
  end

  // Ascending scan: the last hit is the highest index, i.e. highest priority.
  always_comb begin
    vec_nxt = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (pending[i]) vec_nxt = 4'(i);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      status    <= '0;
      enable    <= '0;
      evt_prev  <= '0;
      irq_vec_q <= '0;
    end else begin
      evt_prev  <= bus.evt_in;
      // OR-ing rise last makes a new event win over a same-cycle clear/ack.
      status    <= (status & ~clr_mask & ~ack_mask) | rise;
      irq_vec_q <= vec_nxt;
      if (bus.en_wr) enable <= bus.DEMUX2interrupt_en[NUM_EVT-1:0];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      cnt   <= '0;
      irq_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            state <= ASSERT;
            irq_q <= 1'b1;
          end
        end
        ASSERT: begin
          if (!(|pending)) begin
            irq_q <= 1'b0;
            if (HOLDOFF_CYC == 0) begin
              state <= IDLE;
            end else begin
              state <= HOLDOFF;
              cnt   <= HOLD_LOAD;
            end
          end
        end
        HOLDOFF: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: begin
          state <= IDLE;
          irq_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.interruptstat2MUX = {{(32-NUM_EVT){1'b0}}, status};
  assign bus.interrupten2MUX   = {{(32-NUM_EVT){1'b0}}, enable};
  assign bus.irq               = irq_q;
  assign bus.irq_vec           = irq_vec_q;

  // Upper write-data bits are architecturally ignored.
  logic unused_upper;
  assign unused_upper = ^{bus.DEMUX2interrupt_en[31:NUM_EVT], bus.DEMUX2interrupt_clr[31:NUM_EVT]};

endmodule
